// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: fills a one-entry, 4-byte instruction buffer from a
// byte-wide, variable-latency memory via a request/ack handshake, stalling the CPU on a miss.
module instr_fetch_ctrl #(
  parameter int unsigned MEM_ADDR_W = 10
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           PC,
  output logic [31:0]           INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [MEM_ADDR_W-1:0] MEM_ADDR,
  input  logic [7:0]            MEM_RDATA,
  input  logic                  MEM_ACK
);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t      state;
  logic        buf_valid;
  logic [31:0] buf_tag;
  logic [31:0] buf_data;
  logic [31:0] fill_addr;
  logic [1:0]  fill_idx;
  logic [23:0] sh_data;
  logic        hit;
  logic [1:0]  next_idx;

  assign hit         = buf_valid && (buf_tag == PC);
  assign BUSYWAIT    = !(hit && (state == IDLE));
  assign INSTRUCTION = buf_data;
  assign next_idx    = fill_idx + 2'd1;

  // Bytes 0..2 collect in a shadow register so the visible buffer only ever
  // changes as a whole word, on the edge that accepts the final byte.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
      fill_addr <= '0;
      fill_idx  <= '0;
      sh_data   <= '0;
      MEM_READ  <= 1'b0;
      MEM_ADDR  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            fill_addr <= PC;
            fill_idx  <= '0;
            MEM_READ  <= 1'b1;
            MEM_ADDR  <= PC[MEM_ADDR_W-1:0];
            state     <= FILL;
          end
        end
        FILL: begin
          if (MEM_ACK) begin
            if (fill_idx != 2'd3) begin
              sh_data[fill_idx*8 +: 8] <= MEM_RDATA;
              fill_idx <= next_idx;
              MEM_ADDR <= fill_addr[MEM_ADDR_W-1:0] + MEM_ADDR_W'(next_idx);
            end else begin
              buf_data  <= {MEM_RDATA, sh_data};
              buf_tag   <= fill_addr;
              buf_valid <= 1'b1;
              fill_idx  <= '0;
              MEM_READ  <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
